// File: rtl/fifo_read_ctrl.sv
// Read-domain side of the async FIFO: synchronizes the Gray write pointer,
// produces empty/fill status, issues memory reads and turns the one-cycle
// memory latency into a valid/ready stream through a two-entry buffer
// (output register plus skid register).
module fifo_read_ctrl #(
    parameter int BITSIZE      = 8,
    parameter int ADDRESS_SIZE = 5
) (
    input  logic                    rclk,
    input  logic                    rrst_n,
    input  logic [ADDRESS_SIZE:0]   wptr_gray,
    output logic                    read,
    output logic [ADDRESS_SIZE-1:0] radrs,
    input  logic [BITSIZE-1:0]      rdata,
    output logic [ADDRESS_SIZE:0]   rptr_gray,
    output logic [BITSIZE-1:0]      dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    rempty,
    output logic [ADDRESS_SIZE:0]   rcount
);

    localparam int PW = ADDRESS_SIZE + 1;

    // Write pointer synchronizer; only wq2_reg is used past the chain.
    logic [PW-1:0] wq1_reg;
    logic [PW-1:0] wq2_reg;
    logic [PW-1:0] wq2_bin;

    // Read pointer in both encodings.
    logic [PW-1:0] rptr_bin_reg;
    logic [PW-1:0] rptr_gray_reg;
    logic [PW-1:0] rptr_bin_next;
    logic [PW-1:0] rptr_gray_next;

    // Output buffer state.
    logic               inflight_reg;
    logic               out_valid_reg;
    logic               out_valid_next;
    logic [BITSIZE-1:0] out_data_reg;
    logic [BITSIZE-1:0] out_data_next;
    logic               skid_valid_reg;
    logic               skid_valid_next;
    logic [BITSIZE-1:0] skid_data_reg;
    logic [BITSIZE-1:0] skid_data_next;

    logic       pop;
    logic [1:0] occ;
    logic [1:0] occ_after_pop;

    // Two-flop synchronizer for the Gray write pointer.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            wq1_reg <= '0;
            wq2_reg <= '0;
        end else begin
            wq1_reg <= wptr_gray;
            wq2_reg <= wq1_reg;
        end
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign wq2_bin[gi] = ^wq2_reg[PW-1:gi];
        end
    endgenerate

    assign rptr_bin_next  = rptr_bin_reg + 1'b1;
    assign rptr_gray_next = rptr_bin_next ^ (rptr_bin_next >> 1);

    assign rempty = (rptr_gray_reg == wq2_reg);
    assign rcount = wq2_bin - rptr_bin_reg;

    // Occupancy counts the word returning from memory this cycle plus both
    // buffer slots; a read is only issued if its data is sure to find a slot.
    assign pop           = out_valid_reg & dout_ready;
    assign occ           = {1'b0, inflight_reg} + {1'b0, out_valid_reg} + {1'b0, skid_valid_reg};
    assign occ_after_pop = occ - {1'b0, pop};
    assign read          = !rempty && (occ_after_pop < 2'd2);

    assign radrs      = rptr_bin_reg[ADDRESS_SIZE-1:0];
    assign rptr_gray  = rptr_gray_reg;
    assign dout       = out_data_reg;
    assign dout_valid = out_valid_reg;

    // Advance the read pointer on every issued read; remember the read so the
    // returning data can be captured next cycle.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rptr_bin_reg  <= '0;
            rptr_gray_reg <= '0;
            inflight_reg  <= 1'b0;
        end else begin
            inflight_reg <= read;
            if (read) begin
                rptr_bin_reg  <= rptr_bin_next;
                rptr_gray_reg <= rptr_gray_next;
            end
        end
    end

    // Buffer steering: the skid always drains into the output register first,
    // so the output register holds the oldest word and order is preserved.
    always_comb begin
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        if (pop) begin
            if (skid_valid_reg) begin
                out_data_next = skid_data_reg;
                if (inflight_reg) begin
                    skid_data_next = rdata;
                end else begin
                    skid_valid_next = 1'b0;
                end
            end else if (inflight_reg) begin
                out_data_next = rdata;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (inflight_reg) begin
            if (!out_valid_reg) begin
                out_valid_next = 1'b1;
                out_data_next  = rdata;
            end else begin
                skid_valid_next = 1'b1;
                skid_data_next  = rdata;
            end
        end
    end

    // Output and skid registers; reset discards anything buffered.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
        end else begin
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: a behavioral memory with one-cycle read
// latency, a write-pointer driver and a queue scoreboard on the output stream.
module tb_fifo_read_ctrl;

    logic       rclk = 1'b0;
    logic       rrst_n = 1'b0;
    logic [5:0] wptr_gray = '0;
    logic       read;
    logic [4:0] radrs;
    logic [7:0] rdata = '0;
    logic [5:0] rptr_gray;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
    logic       rempty;
    logic [5:0] rcount;

    logic [7:0] mem [32];
    logic [7:0] exp_q [$];
    int wcnt = 0;
    int n_popped = 0;
    int n_assert = 0;
    int n_fail = 0;

    logic       prev_hold = 1'b0;
    logic [7:0] prev_dout = '0;

    fifo_read_ctrl #(.BITSIZE(8), .ADDRESS_SIZE(5)) dut (
        .rclk(rclk),
        .rrst_n(rrst_n),
        .wptr_gray(wptr_gray),
        .read(read),
        .radrs(radrs),
        .rdata(rdata),
        .rptr_gray(rptr_gray),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .rempty(rempty),
        .rcount(rcount)
    );

    always #5 rclk = ~rclk;

    // Memory with registered read.
    always @(posedge rclk) begin
        if (read) rdata <= mem[radrs];
    end

    function automatic logic [5:0] bin2gray(input int n);
        logic [5:0] b;
        b = 6'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge rclk);
            #1;
        end
    endtask

    task automatic push_word(input logic [7:0] v);
        mem[wcnt % 32] = v;
        exp_q.push_back(v);
        wcnt++;
        wptr_gray = bin2gray(wcnt);
    endtask

    // Stream monitor: order of delivered words and stability under backpressure.
    always @(negedge rclk) begin
        if (!rrst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", {31'b0, dout_valid}, 32'd1);
                chk("hold_data", {24'b0, dout}, {24'b0, prev_dout});
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_pop", {31'b0, dout_valid}, 32'd0);
                end else begin
                    chk("pop_data", {24'b0, dout}, {24'b0, exp_q.pop_front()});
                    n_popped++;
                end
            end
            prev_hold = dout_valid && !dout_ready;
            prev_dout = dout;
        end
    end

    initial begin
        int base;
        int last_rd;
        logic saw_wrap;
        logic saw_msb;

        // Reset values
        repeat (2) @(posedge rclk);
        #1;
        chk("rst_rempty", {31'b0, rempty}, 32'd1);
        chk("rst_read", {31'b0, read}, 32'd0);
        chk("rst_rptr_gray", {26'b0, rptr_gray}, 32'd0);
        chk("rst_radrs", {27'b0, radrs}, 32'd0);
        chk("rst_rcount", {26'b0, rcount}, 32'd0);
        chk("rst_dout_valid", {31'b0, dout_valid}, 32'd0);
        chk("rst_dout", {24'b0, dout}, 32'd0);
        rrst_n = 1'b1;
        dout_ready = 1'b1;

        // Single word: wptr 0->1 launched at edge 0
        step();
        push_word(8'hA5);
        step(); #1;
        chk("sw_c1_read", {31'b0, read}, 32'd0);
        chk("sw_c1_rempty", {31'b0, rempty}, 32'd1);
        step(); #1;
        chk("sw_c2_read", {31'b0, read}, 32'd1);
        chk("sw_c2_radrs", {27'b0, radrs}, 32'd0);
        chk("sw_c2_rcount", {26'b0, rcount}, 32'd1);
        step(); #1;
        chk("sw_c3_rptr_gray", {26'b0, rptr_gray}, 32'd1);
        chk("sw_c3_rempty", {31'b0, rempty}, 32'd1);
        chk("sw_c3_read", {31'b0, read}, 32'd0);
        chk("sw_c3_valid", {31'b0, dout_valid}, 32'd0);
        step(); #1;
        chk("sw_c4_valid", {31'b0, dout_valid}, 32'd1);
        chk("sw_c4_dout", {24'b0, dout}, 32'hA5);
        step(); #1;
        chk("sw_c5_valid", {31'b0, dout_valid}, 32'd0);

        // Backpressure from a fresh reset: 4 words, consumer stalled
        step();
        rrst_n = 1'b0;
        exp_q.delete();
        wcnt = 0;
        wptr_gray = '0;
        step(2);
        rrst_n = 1'b1;
        dout_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) push_word(8'(8'h10 + i));
        chk("bp_wptr_gray", {26'b0, wptr_gray}, 32'd6);
        step(); #1;
        chk("bp_c1_read", {31'b0, read}, 32'd0);
        step(); #1;
        chk("bp_c2_read", {31'b0, read}, 32'd1);
        chk("bp_c2_radrs", {27'b0, radrs}, 32'd0);
        step(); #1;
        chk("bp_c3_read", {31'b0, read}, 32'd1);
        chk("bp_c3_radrs", {27'b0, radrs}, 32'd1);
        step(); #1;
        chk("bp_c4_read", {31'b0, read}, 32'd0);
        chk("bp_c4_valid", {31'b0, dout_valid}, 32'd1);
        step(); #1;
        chk("bp_c5_read", {31'b0, read}, 32'd0);
        chk("bp_c5_rcount", {26'b0, rcount}, 32'd2);
        chk("bp_c5_dout", {24'b0, dout}, 32'h10);
        step();
        chk("bp_c6_read", {31'b0, read}, 32'd0);
        base = n_popped;
        step();
        dout_ready = 1'b1;
        #1;
        chk("bp_refill_read", {31'b0, read}, 32'd1);
        chk("bp_refill_radrs", {27'b0, radrs}, 32'd2);
        for (int k = 0; k < 4; k++) begin
            chk("bp_drain_valid", {31'b0, dout_valid}, 32'd1);
            step(); #1;
        end
        chk("bp_drain_done", {31'b0, dout_valid}, 32'd0);
        chk("bp_popped", 32'(n_popped - base), 32'd4);

        // Streaming: 8 words, consumer always ready (rptr starts at 4)
        base = n_popped;
        step();
        for (int i = 0; i < 8; i++) push_word(8'(8'h20 + 3 * i));
        for (int c = 1; c <= 12; c++) begin
            step(); #1;
            chk("st_read", {31'b0, read}, {31'b0, (c >= 2 && c <= 9)});
            if (c >= 2 && c <= 9) chk("st_radrs", {27'b0, radrs}, 32'(4 + c - 2));
            chk("st_valid", {31'b0, dout_valid}, {31'b0, (c >= 4 && c <= 11)});
        end
        chk("st_popped", 32'(n_popped - base), 32'd8);

        // Stall toggle: ready pattern 1,0,1,0,... while 8 words stream
        base = n_popped;
        step();
        for (int i = 0; i < 8; i++) push_word(8'(8'h80 + 7 * i));
        for (int c = 0; c < 40; c++) begin
            dout_ready = (c % 2 == 0);
            step();
        end
        dout_ready = 1'b1;
        step(3);
        chk("tg_popped", 32'(n_popped - base), 32'd8);

        // Reset mid-stream with output and skid both full
        dout_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) push_word(8'(8'hC0 + i));
        step(6); #1;
        chk("mr_pre_valid", {31'b0, dout_valid}, 32'd1);
        chk("mr_pre_read", {31'b0, read}, 32'd0);
        #1;
        rrst_n = 1'b0;
        exp_q.delete();
        wcnt = 0;
        wptr_gray = '0;
        #1;
        chk("mr_rempty", {31'b0, rempty}, 32'd1);
        chk("mr_valid", {31'b0, dout_valid}, 32'd0);
        chk("mr_rptr_gray", {26'b0, rptr_gray}, 32'd0);
        chk("mr_radrs", {27'b0, radrs}, 32'd0);
        chk("mr_read", {31'b0, read}, 32'd0);
        chk("mr_rcount", {26'b0, rcount}, 32'd0);
        chk("mr_dout", {24'b0, dout}, 32'd0);
        step(2);
        rrst_n = 1'b1;

        // Wrap / full: writer exactly DEPTH ahead, then 40 words in total
        base = n_popped;
        step();
        for (int i = 0; i < 32; i++) push_word(8'(8'h01 + 5 * i));
        step(); #1;
        step(); #1;
        chk("wf_c2_rcount", {26'b0, rcount}, 32'd32);
        chk("wf_c2_rempty", {31'b0, rempty}, 32'd0);
        chk("wf_c2_read", {31'b0, read}, 32'd1);
        step(4);
        push_word(8'h5A);
        push_word(8'h5B);
        step(2); #1;
        chk("wf_full_rcount", {26'b0, rcount}, 32'd32);
        chk("wf_full_rempty", {31'b0, rempty}, 32'd0);
        chk("wf_full_read", {31'b0, read}, 32'd0);
        chk("wf_full_rptr_gray", {26'b0, rptr_gray}, 32'd3);
        dout_ready = 1'b1;
        last_rd = 1;
        saw_wrap = 1'b0;
        saw_msb = 1'b0;
        for (int c = 0; c < 300; c++) begin
            step();
            if (read) begin
                if (last_rd == 31 && radrs == 5'd0) saw_wrap = 1'b1;
                last_rd = int'(radrs);
            end
            if (rptr_gray == 6'd48) saw_msb = 1'b1;
            if ((n_popped - base) >= 10 && wcnt < 40) push_word(8'(8'hE0 + wcnt));
            if ((n_popped - base) >= 40) break;
        end
        step(2);
        chk("wf_radrs_wrap", {31'b0, saw_wrap}, 32'd1);
        chk("wf_msb_toggle", {31'b0, saw_msb}, 32'd1);
        chk("wf_popped", 32'(n_popped - base), 32'd40);
        chk("wf_end_rptr_gray", {26'b0, rptr_gray}, 32'd60);
        chk("wf_end_rempty", {31'b0, rempty}, 32'd1);
        chk("wf_end_rcount", {26'b0, rcount}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
